// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline MEM/WB slice:
// handshake state encoding, default widths and the zero-register index.
package mips_pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dm_state_e;

  // Data memory is word addressed: clear the byte offset.
  function automatic logic [DATA_W_DEF-1:0] word_align(input logic [DATA_W_DEF-1:0] byte_addr);
    word_align = {byte_addr[DATA_W_DEF-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/dm_handshake_fsm.sv
// Data-memory req/ack handshake for the MEM stage.
// Holds the IDLE/WAIT state, latches address/store data/direction while an
// access is outstanding, and produces the stall and completion strobes.
// Optional macro MEM_TIMEOUT_EN adds an abort counter and a sticky error flag.
module dm_handshake_fsm
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memop_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              dm_ack_i,
  output logic              dm_req_o,
  output logic              dm_we_o,
  output logic [DATA_W-1:0] dm_addr_o,
  output logic [DATA_W-1:0] dm_wdata_o,
  output logic              mem_stall_o,
  output logic              done_o,
  output logic              abort_o,
  output logic              mem_err_o
);

  dm_state_e         state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic              req_s, stall_s, timeout_s;

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign timeout_s = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
  assign mem_err_o = err_q;

  // Count WAIT cycles without ack; restart from zero whenever idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if (!dm_ack_i && !timeout_s) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  // Sticky error: set by an abort (a real ack on the limit cycle wins).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (abort_o) begin
      err_q <= 1'b1;
    end else begin
      err_q <= err_q;
    end
  end
`else
  logic unused_cfg_s;
  assign unused_cfg_s = (TIMEOUT_CYCLES > 0) ^ (CNT_W > 0);
  assign timeout_s    = 1'b0;
  assign mem_err_o    = 1'b0;
`endif

  // Next state, latch updates and bus/stall decode.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = we_q;
    req_s      = 1'b0;
    stall_s    = 1'b0;
    done_o     = 1'b0;
    abort_o    = 1'b0;
    dm_we_o    = 1'b0;
    dm_addr_o  = '0;
    dm_wdata_o = '0;
    case (state_q)
      IDLE: begin
        if (memop_i) begin
          req_s      = 1'b1;
          dm_we_o    = we_i;
          dm_addr_o  = addr_i;
          dm_wdata_o = wdata_i;
          if (dm_ack_i) begin
            done_o = 1'b1;
          end else begin
            stall_s = 1'b1;
            state_d = WAIT;
            addr_d  = addr_i;
            data_d  = wdata_i;
            we_d    = we_i;
          end
        end else begin
          req_s = 1'b0;
        end
      end
      WAIT: begin
        req_s      = 1'b1;
        dm_we_o    = we_q;
        dm_addr_o  = addr_q;
        dm_wdata_o = data_q;
        if (dm_ack_i) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end else if (timeout_s) begin
          done_o  = 1'b1;
          abort_o = 1'b1;
          state_d = IDLE;
        end else begin
          stall_s = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request and stall fall the moment reset is applied, not at the next edge.
  assign dm_req_o    = req_s & ~rst;
  assign mem_stall_o = stall_s & ~rst;

  // State and request latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB pipeline register of the pipelined MIPS core.
// Forwards WB data into store data, runs the data-memory handshake and
// registers the write-back triple. Optional macro: MEM_TIMEOUT_EN.
module mem_wb_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_RegWrite,
  input  logic              MEM_MemtoReg,
  input  logic              MEM_MemWrite,
  input  logic [DATA_W-1:0] MEM_ALUorNPC,
  input  logic [DATA_W-1:0] MEM_wmData,
  input  logic [4:0]        MEM_rtAddr,
  input  logic [4:0]        MEM_wrAddr,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ack,
  output logic              mem_stall,
  output logic              mem_err,
  output logic              WB_RegWrite,
  output logic [4:0]        WB_wrAddr,
  output logic [DATA_W-1:0] WB_wdata
);

  logic              wb_regwrite_q;
  logic [4:0]        wb_wraddr_q;
  logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;
  logic              memop_s, fwd_s, done_s, abort_s;
  logic [DATA_W-1:0] st_data_s, word_addr_s;

  assign memop_s     = MEM_MemtoReg | MEM_MemWrite;
  assign fwd_s       = wb_regwrite_q & (wb_wraddr_q != REG_ZERO) & (wb_wraddr_q == MEM_rtAddr);
  assign st_data_s   = fwd_s ? wb_wdata_q : MEM_wmData;
  assign word_addr_s = {MEM_ALUorNPC[DATA_W-1:2], 2'b00};

  dm_handshake_fsm #(
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .memop_i     (memop_s),
    .we_i        (MEM_MemWrite),
    .addr_i      (word_addr_s),
    .wdata_i     (st_data_s),
    .dm_ack_i    (dm_ack),
    .dm_req_o    (dm_req),
    .dm_we_o     (dm_we),
    .dm_addr_o   (dm_addr),
    .dm_wdata_o  (dm_wdata),
    .mem_stall_o (mem_stall),
    .done_o      (done_s),
    .abort_o     (abort_s),
    .mem_err_o   (mem_err)
  );

  // Write-back data select; an aborted load returns zero.
  always_comb begin
    wb_wdata_d = MEM_ALUorNPC;
    if (MEM_MemtoReg) begin
      wb_wdata_d = (done_s && abort_s) ? '0 : dm_rdata;
    end else begin
      wb_wdata_d = MEM_ALUorNPC;
    end
  end

  // MEM/WB register: capture when not stalled, insert a bubble otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_regwrite_q <= 1'b0;
      wb_wraddr_q   <= REG_ZERO;
      wb_wdata_q    <= '0;
    end else if (mem_stall) begin
      wb_regwrite_q <= 1'b0;
      wb_wraddr_q   <= wb_wraddr_q;
      wb_wdata_q    <= wb_wdata_q;
    end else begin
      wb_regwrite_q <= MEM_RegWrite;
      wb_wraddr_q   <= MEM_wrAddr;
      wb_wdata_q    <= wb_wdata_d;
    end
  end

  assign WB_RegWrite = wb_regwrite_q;
  assign WB_wrAddr   = wb_wraddr_q;
  assign WB_wdata    = wb_wdata_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_RegWrite, MEM_MemtoReg, MEM_MemWrite;
  logic [31:0] MEM_ALUorNPC, MEM_wmData;
  logic [4:0]  MEM_rtAddr, MEM_wrAddr;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_ack, mem_stall, mem_err;
  logic        WB_RegWrite;
  logic [4:0]  WB_wrAddr;
  logic [31:0] WB_wdata;

  int errors = 0;
  int checks = 0;

  mem_wb_stage #(.DATA_W(32), .TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemtoReg(MEM_MemtoReg), .MEM_MemWrite(MEM_MemWrite),
    .MEM_ALUorNPC(MEM_ALUorNPC), .MEM_wmData(MEM_wmData),
    .MEM_rtAddr(MEM_rtAddr), .MEM_wrAddr(MEM_wrAddr),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .mem_stall(mem_stall), .mem_err(mem_err),
    .WB_RegWrite(WB_RegWrite), .WB_wrAddr(WB_wrAddr), .WB_wdata(WB_wdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rw, input logic m2r, input logic mw,
                        input logic [31:0] alu, input logic [31:0] wm,
                        input logic [4:0] rt, input logic [4:0] wr);
    MEM_RegWrite = rw; MEM_MemtoReg = m2r; MEM_MemWrite = mw;
    MEM_ALUorNPC = alu; MEM_wmData = wm; MEM_rtAddr = rt; MEM_wrAddr = wr;
  endtask

  task automatic test_reset();
    rst = 1'b1; dm_ack = 1'b0; dm_rdata = 32'h0;
    set_op(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd0, 5'd4);
    tick(); tick();
    checks++;
    if ({WB_RegWrite, WB_wrAddr, WB_wdata} !== {1'b0, 5'd0, 32'h0}) begin
      errors++; $display("FAIL reset_wb: got %b/%0d/%h expected 0/0/0", WB_RegWrite, WB_wrAddr, WB_wdata);
    end
    checks++;
    if ({dm_req, mem_stall, mem_err} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got req/stall/err=%b expected 000", {dm_req, mem_stall, mem_err});
    end
    set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    set_op(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd0, 5'd8);
    #1;
    checks++;
    if ({dm_req, mem_stall} !== 2'b00) begin
      errors++; $display("FAIL alu_ctrl: got req/stall=%b expected 00", {dm_req, mem_stall});
    end
    tick();
    checks++;
    if ({WB_RegWrite, WB_wrAddr, WB_wdata} !== {1'b1, 5'd8, 32'h0000_1234}) begin
      errors++; $display("FAIL alu_wb: got %b/%0d/%h expected 1/8/00001234", WB_RegWrite, WB_wrAddr, WB_wdata);
    end
  endtask

  task automatic test_lw_wait();
    set_op(1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd0, 5'd9);
    dm_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({dm_req, dm_we, mem_stall, dm_addr} !== {1'b1, 1'b0, 1'b1, 32'h0000_0100}) begin
        errors++; $display("FAIL lw_wait_bus[%0d]: got req/we/stall=%b addr=%h expected 101 00000100", i, {dm_req, dm_we, mem_stall}, dm_addr);
      end
      tick();
      checks++;
      if (WB_RegWrite !== 1'b0) begin
        errors++; $display("FAIL lw_bubble[%0d]: got WB_RegWrite=%b expected 0", i, WB_RegWrite);
      end
    end
    dm_ack = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({mem_stall, dm_req, dm_addr} !== {1'b0, 1'b1, 32'h0000_0100}) begin
      errors++; $display("FAIL lw_ack_cycle: got stall/req=%b addr=%h expected 01 00000100", {mem_stall, dm_req}, dm_addr);
    end
    tick();
    dm_ack = 1'b0; dm_rdata = 32'h0;
    set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    checks++;
    if ({WB_RegWrite, WB_wrAddr, WB_wdata} !== {1'b1, 5'd9, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL lw_wb: got %b/%0d/%h expected 1/9/deadbeef", WB_RegWrite, WB_wrAddr, WB_wdata);
    end
  endtask

  task automatic test_sw_forward();
    set_op(1'b1, 1'b0, 1'b0, 32'h0000_0055, 32'h0, 5'd0, 5'd5);
    tick();
    set_op(1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0BAD, 5'd5, 5'd0);
    dm_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({dm_req, dm_we, mem_stall, dm_addr, dm_wdata} !== {3'b111, 32'h0000_0200, 32'h0000_0055}) begin
        errors++; $display("FAIL sw_fwd_wait[%0d]: got req/we/stall=%b addr=%h wdata=%h expected 111 00000200 00000055", i, {dm_req, dm_we, mem_stall}, dm_addr, dm_wdata);
      end
      tick();
    end
    dm_ack = 1'b1;
    #1;
    checks++;
    if ({mem_stall, dm_we, dm_wdata} !== {1'b0, 1'b1, 32'h0000_0055}) begin
      errors++; $display("FAIL sw_fwd_ack: got stall/we=%b wdata=%h expected 01 00000055", {mem_stall, dm_we}, dm_wdata);
    end
    tick();
    dm_ack = 1'b0;
    checks++;
    if (WB_RegWrite !== 1'b0) begin
      errors++; $display("FAIL sw_no_wb: got WB_RegWrite=%b expected 0", WB_RegWrite);
    end
  endtask

  task automatic test_no_fwd_r0();
    set_op(1'b1, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 5'd0, 5'd0);
    tick();
    set_op(1'b0, 1'b0, 1'b1, 32'h0000_0300, 32'h0000_0099, 5'd0, 5'd0);
    dm_ack = 1'b1;
    #1;
    checks++;
    if ({dm_req, mem_stall, dm_wdata} !== {1'b1, 1'b0, 32'h0000_0099}) begin
      errors++; $display("FAIL no_fwd_r0: got req/stall=%b wdata=%h expected 10 00000099", {dm_req, mem_stall}, dm_wdata);
    end
    tick();
    dm_ack = 1'b0;
  endtask

  task automatic test_zero_wait_lw();
    set_op(1'b1, 1'b1, 1'b0, 32'h0000_0013, 32'h0, 5'd0, 5'd3);
    dm_ack = 1'b1; dm_rdata = 32'h0000_0007;
    #1;
    checks++;
    if ({dm_req, mem_stall, dm_addr} !== {1'b1, 1'b0, 32'h0000_0010}) begin
      errors++; $display("FAIL zw_bus: got req/stall=%b addr=%h expected 10 00000010", {dm_req, mem_stall}, dm_addr);
    end
    tick();
    dm_ack = 1'b0; dm_rdata = 32'h0;
    set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    checks++;
    if ({WB_RegWrite, WB_wrAddr, WB_wdata} !== {1'b1, 5'd3, 32'h0000_0007}) begin
      errors++; $display("FAIL zw_wb: got %b/%0d/%h expected 1/3/00000007", WB_RegWrite, WB_wrAddr, WB_wdata);
    end
  endtask

  task automatic test_reset_in_wait();
    set_op(1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'h0000_1111, 5'd2, 5'd0);
    dm_ack = 1'b0;
    tick();
    checks++;
    if ({dm_req, mem_stall} !== 2'b11) begin
      errors++; $display("FAIL rstw_pre: got req/stall=%b expected 11", {dm_req, mem_stall});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({dm_req, mem_stall, WB_RegWrite} !== 3'b000) begin
      errors++; $display("FAIL rstw_drop: got req/stall/wbrw=%b expected 000", {dm_req, mem_stall, WB_RegWrite});
    end
    tick();
    rst = 1'b0;
    set_op(1'b1, 1'b0, 1'b0, 32'h0000_0ABC, 32'h0, 5'd0, 5'd7);
    #1;
    checks++;
    if ({dm_req, mem_stall} !== 2'b00) begin
      errors++; $display("FAIL rstw_idle: got req/stall=%b expected 00", {dm_req, mem_stall});
    end
    tick();
    checks++;
    if ({WB_RegWrite, WB_wrAddr, WB_wdata} !== {1'b1, 5'd7, 32'h0000_0ABC}) begin
      errors++; $display("FAIL rstw_next: got %b/%0d/%h expected 1/7/00000abc", WB_RegWrite, WB_wrAddr, WB_wdata);
    end
  endtask

  task automatic test_ack_ignored();
    set_op(1'b1, 1'b0, 1'b0, 32'h0000_0F0F, 32'h0, 5'd0, 5'd10);
    dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
    #1;
    checks++;
    if ({dm_req, mem_stall} !== 2'b00) begin
      errors++; $display("FAIL ack_ign_ctrl: got req/stall=%b expected 00", {dm_req, mem_stall});
    end
    tick();
    dm_ack = 1'b0;
    checks++;
    if ({WB_RegWrite, WB_wrAddr, WB_wdata} !== {1'b1, 5'd10, 32'h0000_0F0F}) begin
      errors++; $display("FAIL ack_ign_wb: got %b/%0d/%h expected 1/10/00000f0f", WB_RegWrite, WB_wrAddr, WB_wdata);
    end
  endtask

  task automatic test_long_wait();
    int stalls = 0;
    set_op(1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 5'd0, 5'd11);
    dm_ack = 1'b0; dm_rdata = 32'h1234_5678;
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      #1;
      if (mem_stall) begin
        stalls++;
        tick();
      end else begin
        break;
      end
    end
    checks++;
    if (stalls != 17) begin
      errors++; $display("FAIL to_stall_cycles: got %0d expected 17", stalls);
    end
    tick();
    set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    checks++;
    if ({WB_RegWrite, WB_wrAddr, WB_wdata, mem_err} !== {1'b1, 5'd11, 32'h0, 1'b1}) begin
      errors++; $display("FAIL to_wb: got %b/%0d/%h err=%b expected 1/11/00000000 err=1", WB_RegWrite, WB_wrAddr, WB_wdata, mem_err);
    end
    tick(); tick();
    checks++;
    if (mem_err !== 1'b1) begin
      errors++; $display("FAIL to_sticky: got mem_err=%b expected 1", mem_err);
    end
`else
    for (int i = 0; i < 30; i++) begin
      #1;
      if (mem_stall) stalls++;
      tick();
    end
    checks++;
    if ({stalls, mem_err} !== {32'd30, 1'b0}) begin
      errors++; $display("FAIL long_wait: got stalls=%0d err=%b expected 30 0", stalls, mem_err);
    end
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    checks++;
    if ({WB_RegWrite, WB_wrAddr, WB_wdata} !== {1'b1, 5'd11, 32'h1234_5678}) begin
      errors++; $display("FAIL long_wait_wb: got %b/%0d/%h expected 1/11/12345678", WB_RegWrite, WB_wrAddr, WB_wdata);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lw_wait();
    test_sw_forward();
    test_no_fwd_r0();
    test_zero_wait_lw();
    test_reset_in_wait();
    test_ack_ignored();
    test_long_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM stage plus MEM/WB pipeline register of the pipelined MIPS core.
- Consumes the EX/MEM register outputs and performs the data-memory access over a req/ack handshake.
- Forwards WB-stage data into store data, and registers the write-back triple (RegWrite, wrAddr, wdata) for the register file.
- Raises mem_stall while a memory access is outstanding; EX/MEM and all upstream registers hold while mem_stall=1.

Parameters:
- DATA_W, 32, data and address width.
- TIMEOUT_CYCLES, 16, WAIT-state cycle limit (used only with MEM_TIMEOUT_EN).
- CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- MEM_RegWrite  in  1  instruction writes the register file.
- MEM_MemtoReg  in  1  load: write-back data comes from memory.
- MEM_MemWrite  in  1  store.
- MEM_ALUorNPC  in  DATA_W  ALU result / link address; doubles as memory byte address.
- MEM_wmData  in  DATA_W  store data from EX.
- MEM_rtAddr  in  5  rt of the store, used for forwarding.
- MEM_wrAddr  in  5  destination register.
- dm_req  out  1  memory request.
- dm_we  out  1  1 = write, 0 = read.
- dm_addr  out  DATA_W  word address = byte address with [1:0] forced to 0.
- dm_wdata  out  DATA_W  store data.
- dm_rdata  in  DATA_W  read data, valid when dm_ack=1.
- dm_ack  in  1  access complete this cycle.
- mem_stall  out  1  hold EX/MEM and upstream; bubble into WB.
- mem_err  out  1  sticky timeout flag (MEM_TIMEOUT_EN only, else tied 0).
- WB_RegWrite  out  1  registered.
- WB_wrAddr  out  5  registered.
- WB_wdata  out  DATA_W  registered.

Behaviour:
- Reset: state=IDLE, WB_RegWrite=0, WB_wrAddr=0, WB_wdata=0, latched addr/data/we=0, mem_err=0. dm_req and mem_stall drop immediately, since both are derived from state and rst.
- Memory op: memop = MEM_MemtoReg | MEM_MemWrite.
- Store-data forward:
  - fwd = WB_RegWrite & (WB_wrAddr != 0) & (WB_wrAddr == MEM_rtAddr).
  - st_data = fwd ? WB_wdata : MEM_wmData.
- IDLE:
  - If memop: dm_req=1, dm_we=MEM_MemWrite, dm_addr/dm_wdata driven combinationally from the inputs.
  - dm_ack=1 in the same cycle (zero-wait): mem_stall=0, WB register captures, stay IDLE.
  - dm_ack=0: mem_stall=1; latch addr, st_data and we into internal registers; go WAIT. WB captures a bubble (WB_RegWrite=0).
  - No memop: no request, mem_stall=0, WB captures normally.
- WAIT:
  - dm_req=1; dm_addr/dm_wdata/dm_we come from the latched copies and are stable until ack.
  - dm_ack=0: mem_stall=1, WB bubble each cycle.
  - dm_ack=1: mem_stall=0, WB captures the still-held instruction, go IDLE next edge.
- Latching rationale: the latched store data guarantees the forwarded value survives the WB bubbles.
- WB capture when not stalled:
  - WB_RegWrite <= MEM_RegWrite.
  - WB_wrAddr <= MEM_wrAddr.
  - WB_wdata <= MEM_MemtoReg ? dm_rdata : MEM_ALUorNPC.
- Store with RegWrite=1 is illegal input; the block still writes back ALUorNPC.
- Latency: 1 cycle from MEM to WB for non-memory ops and zero-wait accesses; N+1 cycles for an ack after N wait cycles.
- Reset asserted in WAIT: request abandoned, no WB write, state IDLE.
- dm_ack while dm_req=0: ignored.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - CNT_W counter cleared on entry to WAIT, incremented each WAIT cycle without ack.
  - When the count reaches TIMEOUT_CYCLES, the access is aborted: behaves as ack with dm_rdata taken as 0. mem_err is set and stays set until rst.
  - A real ack arriving in the same cycle as the limit wins; mem_err is not set.
- Undefined: no counter; WAIT lasts until ack indefinitely; mem_err tied 0.

Decomposition:
- Package mips_pipe_pkg: state enum (IDLE, WAIT), DATA_W default, REG_ZERO=5'd0.
- Sub-module dm_handshake_fsm: state register, request latches and the optional timeout counter. Outputs dm_*, mem_stall, done, mem_err.
- Top level keeps the forwarding mux and the WB register.

Test Plan:
- ADD result 0x0000_1234, wr=8, no memop -> next edge WB_RegWrite=1, WB_wrAddr=8, WB_wdata=0x1234, mem_stall never 1.
- LW addr 0x0000_0102, ack 3 cycles after req, rdata 0xDEAD_BEEF:
  - dm_addr=0x100, dm_we=0, mem_stall=1 for 3 cycles with WB_RegWrite=0.
  - Then WB_wdata=0xDEADBEEF.
- SW rt=5 immediately after ADD writing r5=0x55 (now in WB), ack after 2 cycles -> dm_wdata=0x55 latched and stable through WAIT, dm_we=1.
- Zero-wait LW (ack same cycle as req), rdata 0x7 -> no stall, WB_wdata=0x7 after 1 cycle.
- rst pulse during WAIT of an SW -> dm_req=0 immediately, WB_RegWrite=0, state IDLE, next instruction proceeds.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack never asserted -> abort after 16 WAIT cycles, mem_err=1 sticky, WB_wdata=0 for the LW.
